// File: rtl/dkong_snd_gain_sched.sv
`default_nettype none
//==============================================================================
// Module      : dkong_snd_gain_sched
// Description : Time-multiplexed gain-envelope scheduler and mixer. Once per
//               sample period, walks NCH channels through one shared signed
//               multiplier, applies a per-channel discharge/recharge envelope
//               and sums the scaled channels into one saturated 16-bit sample.
// Revision    : 1.0  initial release
//==============================================================================
module dkong_snd_gain_sched #(
    parameter int DIV = 512,
    parameter int NCH = 4
) (
    input  logic                I_CLK,
    input  logic                I_RESET_n,
    input  logic [16*NCH-1:0]   I_SND_DAT,
    input  logic [NCH-1:0]      I_DECAY_EN,
    input  logic                I_CFG_WE,
    input  logic [2:0]          I_CFG_CH,
    input  logic [7:0]          I_CFG_RATE,
    output logic [15:0]         O_SND_DAT,
    output logic                O_VLD,
    output logic                O_BUSY
);

    localparam int             c_tw   = $clog2(DIV);
    localparam logic [c_tw-1:0] c_tmax = c_tw'(DIV - 1);
    localparam logic [2:0]     c_last = 3'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ch;
    logic [c_tw-1:0]    r_timer;
    logic               r_strobe;

    logic [7:0]         r_gain [NCH];
    logic [7:0]         r_cnt  [NCH];
    logic [7:0]         r_rate [NCH];

    logic signed [15:0] r_op_dat;
    logic [7:0]         r_op_gain;
    logic signed [18:0] r_acc;
    logic [15:0]        r_dat;
    logic               r_vld;
    logic               r_busy;

    logic [15:0]        w_dat_sel;
    logic [7:0]         w_gain_sel;
    logic signed [24:0] w_op_a;
    logic signed [24:0] w_op_b;
    logic signed [24:0] w_prod;
    logic signed [18:0] w_term;
    logic signed [18:0] w_acc_nx;
    logic [15:0]        w_sat;
    logic               w_cap;

    assign w_cap = (r_state == ST_CAP);

    // Free-running sample timer; strobe is registered one cycle after wrap point
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_timer  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_timer == c_tmax);
            r_timer  <= (r_timer == c_tmax) ? '0 : r_timer + 1'b1;
        end
    end

    // Select the current channel's sample and pre-update gain for the operand latch
    always_comb begin
        w_dat_sel  = '0;
        w_gain_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_ch == 3'(c)) begin
                w_dat_sel  = I_SND_DAT[16*c +: 16];
                w_gain_sel = r_gain[c];
            end
        end
    end

    // Per-channel envelope update during CAP and runtime rate register writes
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_gain[c] <= 8'd255;
                r_cnt[c]  <= 8'd0;
                r_rate[c] <= 8'd0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_cap && (r_ch == 3'(c))) begin
                    if (I_DECAY_EN[c]) begin
                        // Comparison uses the rate held before this edge, so a
                        // write landing in the same cycle only affects later samples
                        if (r_cnt[c] == r_rate[c]) begin
                            r_cnt[c] <= 8'd0;
                            if (r_gain[c] != 8'd0)
                                r_gain[c] <= r_gain[c] - 8'd1;
                        end else begin
                            r_cnt[c] <= r_cnt[c] + 8'd1;
                        end
                    end else begin
                        r_cnt[c] <= 8'd0;
                        if (r_gain[c] != 8'd255)
                            r_gain[c] <= r_gain[c] + 8'd1;
                    end
                end
                // Channel indices >= NCH never match, so such writes are dropped
                if (I_CFG_WE && (I_CFG_CH == 3'(c)))
                    r_rate[c] <= I_CFG_RATE;
            end
        end
    end

    // Shared multiplier: signed sample times unsigned 8-bit gain, scaled by 1/256
    assign w_op_a   = {{9{r_op_dat[15]}}, r_op_dat};
    assign w_op_b   = {17'd0, r_op_gain};
    assign w_prod   = w_op_a * w_op_b;
    assign w_term   = 19'(w_prod >>> 8);
    assign w_acc_nx = r_acc + w_term;

    // Clamp the final accumulator value into the 16-bit signed output range
    always_comb begin
        if ((w_acc_nx[18:15] == 4'b0000) || (w_acc_nx[18:15] == 4'b1111))
            w_sat = w_acc_nx[15:0];
        else if (w_acc_nx[18])
            w_sat = 16'h8000;
        else
            w_sat = 16'h7FFF;
    end

    // Sequencer: IDLE -> (CAP, MUL) per channel -> OUT, with registered outputs.
    // The output sample is loaded on the last MUL so it is valid alongside O_VLD.
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_state   <= ST_IDLE;
            r_ch      <= 3'd0;
            r_op_dat  <= '0;
            r_op_gain <= '0;
            r_acc     <= '0;
            r_dat     <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_strobe) begin
                        r_state <= ST_CAP;
                        r_ch    <= 3'd0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAP: begin
                    r_op_dat  <= w_dat_sel;
                    r_op_gain <= w_gain_sel;
                    r_state   <= ST_MUL;
                end
                ST_MUL: begin
                    r_acc <= w_acc_nx;
                    if (r_ch == c_last) begin
                        r_state <= ST_OUT;
                        r_dat   <= w_sat;
                        r_vld   <= 1'b1;
                    end else begin
                        r_ch    <= r_ch + 3'd1;
                        r_state <= ST_CAP;
                    end
                end
                ST_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign O_SND_DAT = r_dat;
    assign O_VLD     = r_vld;
    assign O_BUSY    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dkong_snd_gain_sched.sv
`default_nettype none
//==============================================================================
// Module      : tb_dkong_snd_gain_sched
// Description : Scoreboard bench for dkong_snd_gain_sched. A driver computes
//               each expected sample from a behavioural envelope/mixer model
//               and queues it; a monitor pops and compares on every O_VLD and
//               checks sample spacing and busy window length.
// Revision    : 1.0  initial release
//==============================================================================
module tb_dkong_snd_gain_sched;

    localparam int DIV = 64;
    localparam int NCH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [16*NCH-1:0]   snd = '0;
    logic [NCH-1:0]      decay = '0;
    logic                cfg_we = 1'b0;
    logic [2:0]          cfg_ch = '0;
    logic [7:0]          cfg_rate = '0;
    logic [15:0]         out_dat;
    logic                out_vld;
    logic                out_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];

    int m_gain [NCH];
    int m_cnt  [NCH];
    int m_rate [NCH];

    dkong_snd_gain_sched #(.DIV(DIV), .NCH(NCH)) dut (
        .I_CLK      (clk),
        .I_RESET_n  (rst_n),
        .I_SND_DAT  (snd),
        .I_DECAY_EN (decay),
        .I_CFG_WE   (cfg_we),
        .I_CFG_CH   (cfg_ch),
        .I_CFG_RATE (cfg_rate),
        .O_SND_DAT  (out_dat),
        .O_VLD      (out_vld),
        .O_BUSY     (out_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: run did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_gain[c] = 255;
            m_cnt[c]  = 0;
            m_rate[c] = 0;
        end
    endfunction

    // One sample: mix with current gains, then advance each envelope once
    function automatic logic [15:0] model_step();
        int sum;
        int d;
        sum = 0;
        for (int c = 0; c < NCH; c++) begin
            d = int'($signed(snd[16*c +: 16]));
            sum += (d * m_gain[c]) >>> 8;
            if (decay[c]) begin
                if (m_cnt[c] == m_rate[c]) begin
                    m_cnt[c] = 0;
                    if (m_gain[c] > 0) m_gain[c] = m_gain[c] - 1;
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) % 256;
                end
            end else begin
                m_cnt[c] = 0;
                if (m_gain[c] < 255) m_gain[c] = m_gain[c] + 1;
            end
        end
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return 16'(sum);
    endfunction

    task automatic set_in(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input logic [3:0] dec);
        snd   = {d3, d2, d1, d0};
        decay = dec;
    endtask

    task automatic wait_vld();
        for (int i = 0; i < 2 * DIV + 20; i++) begin
            @(negedge clk);
            if (out_vld) return;
        end
        checks++;
        errors++;
        $display("FAIL vld_timeout: got no O_VLD, required one within %0d cycles", 2 * DIV + 20);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 2 * DIV + 20; i++) begin
            @(negedge clk);
            if (out_busy) return;
        end
        checks++;
        errors++;
        $display("FAIL busy_timeout: got no O_BUSY, required one within %0d cycles", 2 * DIV + 20);
    endtask

    task automatic run_sample();
        sb_q.push_back(model_step());
        wait_vld();
    endtask

    // Rate write issued while the sequencer is idle
    task automatic cfg_write(input logic [2:0] ch, input logic [7:0] rate);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_rate = rate;
        @(negedge clk);
        cfg_we   = 1'b0;
        if (int'(ch) < NCH) m_rate[ch] = int'(rate);
    endtask

    // Monitor: compare every presented sample and its timing
    initial begin
        int since;
        int last;
        int busy_run;
        bit first;
        logic [15:0] exp;
        since = 0; last = 0; busy_run = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                since = 0;
                first = 1'b1;
                busy_run = 0;
            end else begin
                since++;
                if (out_busy) busy_run++;
                if (out_vld) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vld: got O_VLD with data 0x%0h, required no pulse", out_dat);
                    end else begin
                        exp = sb_q.pop_front();
                        check("sample", int'(out_dat), int'(exp));
                    end
                    if (first) check("first_vld_latency", since, DIV + 9);
                    else       check("vld_spacing", since - last, DIV);
                    check("busy_window", busy_run, 2 * NCH + 1);
                    first = 1'b0;
                    last = since;
                    busy_run = 0;
                end
            end
        end
    end

    // Driver
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_dat", int'(out_dat), 0);
        check("rst_vld", int'(out_vld), 0);
        check("rst_busy", int'(out_busy), 0);
        #1 rst_n = 1'b1;

        // Single channel, full gain
        set_in(16'h4000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
        run_sample();
        run_sample();

        // Positive and negative saturation
        set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b0000);
        run_sample();
        set_in(16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b0000);
        run_sample();

        // Slow decay on ch1, one step every third sample
        cfg_write(3'd1, 8'd2);
        set_in(16'h0000, 16'h4000, 16'h0000, 16'h0000, 4'b0010);
        for (int i = 0; i < 10; i++) run_sample();

        // Full discharge then full recharge on ch0 at rate 0
        set_in(16'h4000, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
        for (int i = 0; i < 300; i++) run_sample();
        set_in(16'h4000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
        for (int i = 0; i < 260; i++) run_sample();

        // Rate write landing exactly on CAP(2)
        set_in(16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 4'b0100);
        run_sample();
        run_sample();
        sb_q.push_back(model_step());
        wait_busy();
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_rate = 8'd3;
        @(negedge clk);
        cfg_we = 1'b0;
        m_rate[2] = 3;
        wait_vld();
        for (int i = 0; i < 6; i++) run_sample();

        // Out-of-range channel write changes nothing
        cfg_write(3'd5, 8'h00);
        set_in(16'h2000, 16'h3000, 16'h7FFF, 16'h1000, 4'b0110);
        for (int i = 0; i < 6; i++) run_sample();

        // Random traffic with occasional rate writes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)));
            snd   = {$urandom, $urandom};
            decay = 4'($urandom);
            run_sample();
        end

        // Reset in the middle of a sequence
        set_in(16'h1234, 16'h4000, 16'hC000, 16'h7FFF, 4'b1111);
        wait_busy();
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_dat", int'(out_dat), 0);
        check("abort_vld", int'(out_vld), 0);
        check("abort_busy", int'(out_busy), 0);
        repeat (3) @(negedge clk);
        model_reset();
        #1 rst_n = 1'b1;
        set_in(16'h4000, 16'h4000, 16'h0000, 16'h0000, 4'b0011);
        for (int i = 0; i < 3; i++) run_sample();

        repeat (5) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
